// File: rtl/stim_serial_tx_if.sv
// Word handshake between the stimulus sequencer and the serial transmitter.
//   in_data   : word to send, sampled when in_valid && out_ready
//   in_valid  : sequencer has a word
//   out_ready : transmitter is idle and can take a word
// master = sequencer side, slave = transmitter side.
interface stim_serial_tx_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_ready
    );
endinterface

// File: rtl/stim_serial_tx.sv
// stim_serial_tx: bit-serial transmitter driving a DUT's 1-bit sampled input.
// Frames an accepted word as start bit, WIDTH data bits LSB first, optional
// even-parity bit, stop bit; every line bit is held for CLKS_PER_BIT cycles.
//
// Optional feature: define STIM_TX_PARITY_EN to insert a PARITY state
// between DATA and STOP.
//
// Ports:
//   clock_10   : clock, rising edge
//   clock_12   : synchronous active-high reset
//   bus        : slave side of the word handshake (in_data/in_valid/out_ready)
//   out_serial : registered serial line
//   out_busy   : registered, high while a frame is in progress
//   out_done   : registered, one-cycle pulse on the last stop-bit cycle
module stim_serial_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic                  clock_10,
    input  logic                  clock_12,
    stim_serial_tx_if.slave       bus,
    output logic                  out_serial,
    output logic                  out_busy,
    output logic                  out_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

`ifdef STIM_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               serial_q, serial_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef STIM_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic               cnt_wrap_c;
    logic               accept_c;

    assign cnt_wrap_c = (cnt_q == CNT_LAST);
    assign accept_c   = bus.in_valid && ready_q;

    // State register and registered outputs
    always_ff @(posedge clock_10) begin
        if (clock_12) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= IDLE_LEVEL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef STIM_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef STIM_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state, counters and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef STIM_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d  = START;
                    cnt_d    = '0;
                    bit_d    = '0;
                    shift_d  = bus.in_data;
`ifdef STIM_TX_PARITY_EN
                    parity_d = ^bus.in_data;
`endif
                end
            end

            START: begin
                if (cnt_wrap_c) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_wrap_c) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef STIM_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef STIM_TX_PARITY_EN
            PARITY: begin
                if (cnt_wrap_c) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (cnt_wrap_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output next values derived from the upcoming state so the line is registered
    always_comb begin
        serial_d = IDLE_LEVEL;
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
        // Done lands on the final stop cycle: entering STOP's last count
        done_d   = (state_d == STOP) && (cnt_d == CNT_LAST);

        unique case (state_d)
            IDLE:    serial_d = IDLE_LEVEL;
            START:   serial_d = ~IDLE_LEVEL;
            DATA:    serial_d = shift_d[0];
`ifdef STIM_TX_PARITY_EN
            PARITY:  serial_d = parity_d;
`endif
            STOP:    serial_d = IDLE_LEVEL;
            default: serial_d = IDLE_LEVEL;
        endcase
    end

    assign bus.out_ready = ready_q;
    assign out_serial    = serial_q;
    assign out_busy      = busy_q;
    assign out_done      = done_q;

endmodule
